// File: rtl/mem_read_port.sv
// ============================================================================
// mem_read_port
// ----------------------------------------------------------------------------
// Per-agent read front end for the multi-port RAM. Turns a valid/ready read
// request stream into the RAM's fixed-latency rden/rdaddr strobes, realigns
// the returning rddata through a valid-bit pipe, and buffers it in a small
// response FIFO that drives a valid/ready response stream.
//
// Flow control is credit based. One credit is held for every FIFO slot. A
// request consumes a credit when it is issued, and the credit comes back when
// its response is popped. So the FIFO occupancy plus the reads still in
// flight can never exceed FIFO_DEPTH. Data returning from the RAM therefore
// always has a free slot and is never dropped.
//
// Handshake rule for both streams: a transfer happens on a rising edge of
// aclk where valid && ready are both high. A producer holds valid (and its
// payload) until that edge. Here req_ready and rsp_valid depend only on
// registered state and aresetn, never on req_valid or rsp_ready.
//
// Optional feature (macro MEM_RDPORT_STATS_EN):
//   When defined, adds output stall_cnt. It is a 16-bit saturating count of
//   cycles with req_valid && !req_ready. Only reset clears it.
//
// Parameters:
//   ADDR_WIDTH  RAM address width
//   DATA_WIDTH  RAM data width
//   RD_LATENCY  cycles from mem_rden high to mem_rddata valid (>= 1)
//   FIFO_DEPTH  response FIFO entries (power of two, >= 2)
//
// Ports:
//   aclk        clock
//   aresetn     synchronous active-low reset
//   req_valid   read request valid
//   req_ready   request accepted when req_valid && req_ready
//   req_addr    read address
//   rsp_valid   response data valid
//   rsp_ready   consumer accepts response
//   rsp_data    read data, returned in request order
//   mem_rden    RAM read enable (combinational issue)
//   mem_rdaddr  RAM read address (follows req_addr)
//   mem_rddata  RAM read data, valid RD_LATENCY cycles after mem_rden
//   stall_cnt   stall statistics (MEM_RDPORT_STATS_EN only)
// ============================================================================
module mem_read_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_rden,
    output logic [ADDR_WIDTH-1:0] mem_rdaddr,
    input  logic [DATA_WIDTH-1:0] mem_rddata
`ifdef MEM_RDPORT_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_INIT = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;

    logic [CNT_W-1:0]      r_credits;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [CNT_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Request side: issue straight through to the RAM in the accept cycle.
    // req_ready is forced low during reset, so nothing issues while the
    // credit counter and pipe are being cleared.
    // ------------------------------------------------------------------
    assign req_ready  = aresetn && (r_credits != '0);
    assign w_issue    = req_valid && req_ready;
    assign mem_rden   = w_issue;
    assign mem_rdaddr = req_addr;

    // ------------------------------------------------------------------
    // Response side handshake
    // ------------------------------------------------------------------
    assign rsp_valid = !w_empty;
    assign w_pop     = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // Credit counter. An issue and a pop in the same cycle cancel. A credit
    // freed by a pop only shows up on req_ready in the next cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_credits <= CREDIT_INIT;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CNT_W'(1);
                2'b01:   r_credits <= r_credits + CNT_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Latency pipe: one valid bit per RAM pipeline stage. The tail bit
    // marks the cycle in which mem_rddata belongs to an issued read.
    // Clearing it on reset makes late RAM data arriving after reset
    // invisible.
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_issue;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[RD_LATENCY-2:0], w_issue};
                end
            end
        end
    endgenerate

    assign w_push = r_pipe[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // Response FIFO. The pointers carry one extra wrap bit. Equal pointers
    // mean empty. Equal index bits with different wrap bits mean full.
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only visible once the write
    // pointer has moved past it.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= mem_rddata;
        end
    end

    // The head entry only changes when the read pointer moves. So rsp_data
    // holds steady while rsp_valid && !rsp_ready.
    assign rsp_data = r_fifo[r_rd_ptr[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Credits make these unreachable. They flag a broken credit loop in
    // simulation.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (aresetn && w_push) begin
            assert (!w_full)
                else $error("mem_read_port: response FIFO written while full");
        end
        if (aresetn) begin
            assert (r_credits <= CREDIT_INIT)
                else $error("mem_read_port: credit counter above FIFO_DEPTH");
        end
    end

`ifdef MEM_RDPORT_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics: cycles in which the agent wanted to issue but had
    // no credit. The count saturates instead of wrapping, so a full-scale
    // value means "at least this many".
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_stall_cnt <= '0;
        end else if (req_valid && !req_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/mem_read_port.md
# mem_read_port

Per-agent read front end for the multi-port RAM. Converts a valid/ready read request stream into the RAM's fixed-latency `rden`/`rdaddr` strobes, realigns the returning `rddata`, and presents it as a valid/ready response stream with full backpressure. It is credit-based, so returning data can never be dropped. One instance sits in front of each read agent (`rden1/rdaddr1/rddata1`, `rden2/...`) of the top-level RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, RAM address width in bits
- `DATA_WIDTH`, 32, RAM data width in bits
- `RD_LATENCY`, 2, cycles from `mem_rden` high to `mem_rddata` valid; legal ≥1
- `FIFO_DEPTH`, 4, response FIFO entries; power of two, ≥2

Ports:
- `aclk` in 1, single clock
- `aresetn` in 1, reset; synchronous, active-low
- `req_valid` in 1, read request valid
- `req_ready` out 1, request accepted when `req_valid && req_ready`
- `req_addr` in ADDR_WIDTH, read address
- `rsp_valid` out 1, response data valid
- `rsp_ready` in 1, consumer accepts response
- `rsp_data` out DATA_WIDTH, read data, returned in request order
- `mem_rden` out 1, to RAM read enable
- `mem_rdaddr` out ADDR_WIDTH, to RAM read address
- `mem_rddata` in DATA_WIDTH, from RAM read data
- `stall_cnt` out 16, present only with `MEM_RDPORT_STATS_EN`

## Operation
- Credit counter `credits`, width clog2(FIFO_DEPTH)+1, resets to FIFO_DEPTH.
- `req_ready = aresetn && (credits != 0)`.
- Issue is combinational: `mem_rden = req_valid && req_ready` and `mem_rdaddr = req_addr`.
- Issue decrements `credits`. A response pop (`rsp_valid && rsp_ready`) increments it. Issue and pop in the same cycle leave it unchanged.
- Latency pipe: a shift register of RD_LATENCY valid bits. Stage 0 loads `mem_rden`. When the tail bit is set, `mem_rddata` is sampled into the FIFO at that edge.
- Response FIFO: ptr width clog2(FIFO_DEPTH)+1 with wrap bit.
  - empty when ptrs are equal.
  - `rsp_valid = !empty`.
  - `rsp_data` = head entry; it is stable while `rsp_valid && !rsp_ready`.
- Credits guarantee that FIFO occupancy plus in-flight reads ≤ FIFO_DEPTH. A FIFO write while full cannot occur; a simulation assertion flags it.
- Simultaneous FIFO push and pop are both performed, with occupancy unchanged.
- No address checking or reordering; responses are strictly FIFO ordered.

## Timing
- Reset values:
  - `req_ready` 0 while `aresetn` low, then 1 from the first cycle after release.
  - `rsp_valid` 0, `mem_rden` 0, pipe cleared, FIFO ptrs 0, `credits` FIFO_DEPTH, `stall_cnt` 0.
- Request accepted in cycle T:
  - `mem_rden` is high in T.
  - `mem_rddata` is valid in T+RD_LATENCY and written at the end of that cycle.
  - `rsp_valid` goes high in T+RD_LATENCY+1.
  - Minimum request→response latency is RD_LATENCY+1.
- A credit returned by a pop in cycle P is usable in P+1.
- Sustained 1 read/cycle with `rsp_ready` tied high requires FIFO_DEPTH ≥ RD_LATENCY+2. Smaller depths throttle `req_ready` but remain functionally correct.
- Reset mid-operation: in-flight reads and FIFO contents are discarded. RAM data arriving after reset is ignored because the pipe is cleared.
- `rsp_ready` held low: at most FIFO_DEPTH requests are accepted, then `req_ready` is 0 until a pop.

## Configuration
- `MEM_RDPORT_STATS_EN` defined:
  - Adds output `stall_cnt`, a 16-bit counter.
  - Increments each cycle `req_valid && !req_ready`.
  - Saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then a single request (defaults) with `req_addr`=8'h10 and RAM model returning 32'hDEAD_0010 → `mem_rden` pulses in T; `rsp_valid`=1 with `rsp_data`=32'hDEAD_0010 in T+3; `credits` back to 4 one cycle after the pop.
- Back-to-back addresses 0..15, `rsp_ready`=1, FIFO_DEPTH=4, RD_LATENCY=2 → `req_ready` stays 1; 16 responses in order, one per cycle, each data = f(addr).
- `rsp_ready`=0 with `req_valid`=1 continuously → exactly 4 accepts, then `req_ready`=0. Raising `rsp_ready` drains 4 responses in order and resumes issuing.
- Random `rsp_ready` (50%) over 1000 requests → no loss, no duplication, in-order data, and the FIFO-overflow assertion never fires.
- `aresetn` low for 1 cycle with 2 reads in flight and 2 entries buffered → `rsp_valid`=0 next cycle; the late RAM data is not delivered; `credits`=4.
- With `MEM_RDPORT_STATS_EN`: 10 back-pressured stall cycles → `stall_cnt`=10; forced 70000 stall cycles → `stall_cnt`=16'hFFFF.
